axil_regfile_slave: RTL and testbench
=====================================

Name: axil_regfile_slave

Overview:
Parametrised AXI4-Lite slave that terminates the bus in the NextEmu RTL adapter with a bank of NUM_REGS memory-mapped registers.
- Successor to the fixed 32-bit wrapper top: generalised in data/address width, register count and base address.
- Adds independent AW/W acceptance, byte-strobe writes, SLVERR decode and backpressure-safe response channels.
- Register contents are exported flat to the emulated design.

Parameters:
ADDR_WIDTH, 32, width of AWADDR/ARADDR
DATA_WIDTH, 32, width of WDATA/RDATA; legal values 32 or 64
NUM_REGS, 16, number of registers (>=1)
BASE_ADDR, 0, byte address of register 0; must be aligned to DATA_WIDTH/8

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWADDR  in  ADDR_WIDTH  write byte address
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte enables
BVALID  out  1  write response valid
BREADY  in  1  write response ready
BRESP  out  2  write response
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
ARADDR  in  ADDR_WIDTH  read byte address
RVALID  out  1  read data valid
RREADY  in  1  read data ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
regs_q  out  NUM_REGS*DATA_WIDTH  register contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (ARESETn low, async): all registers 0. AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; BRESP, RRESP, RDATA = 0. Pending transactions are discarded.
  - READY outputs rise on the first ACLK edge after deassertion.
- Address decode: offset = addr - BASE_ADDR. idx = offset >> log2(DATA_WIDTH/8); sub-word address bits are ignored.
  - Hit if addr >= BASE_ADDR and idx < NUM_REGS; otherwise miss.
- Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP.
  - AWREADY = 1 in IDLE/HAVE_W. WREADY = 1 in IDLE/HAVE_AW.
  - AW and W may arrive in either order or together; each is latched on its own handshake.
  - Commit edge: the edge on which both are held. On a hit, bytes with WSTRB[b]=1 are written and others are unchanged. On a miss, nothing is written.
  - Next cycle: state RESP, BVALID=1, BRESP=2'b00 (OKAY) on hit or 2'b10 (SLVERR) on miss.
  - In RESP: AWREADY = WREADY = 0. BVALID and BRESP hold until BREADY; then return to IDLE with READYs high the next cycle.
  - Best-case latency: AW+W handshake at cycle N gives BVALID at N+1.
- Read FSM states: R_IDLE, R_RESP.
  - ARREADY = 1 in R_IDLE only.
  - On handshake, RDATA and RRESP are registered: register value / OKAY on hit, 0 / SLVERR on miss. RVALID=1 the next cycle.
  - RDATA, RRESP and RVALID stay stable until RREADY; then return to R_IDLE.
- Simultaneous read and write to the same register on the same edge: the read returns the pre-write value.
- Read and write FSMs are fully independent.
- regs_q reflects a committed write one cycle after the commit edge.

Optional Feature:
AXIL_REGFILE_WR_PULSE_EN
- Defined: adds output wr_pulse [NUM_REGS]. Bit i is high for exactly one cycle, coincident with BVALID rising, when a hit write commits to register i (including WSTRB=0). Reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - write/read state enum typedefs
  - localparams STRB_W=DATA_WIDTH/8 and ADDR_LSB=$clog2(STRB_W)
- One sub-module, axil_wr_chan: write FSM, AW/W latches, B channel. Outputs commit strobe, idx, hit, data, strb.
- Top holds the register array and read FSM.

Test Plan:
- Reset then AW=0x08 and W=0xDEADBEEF, WSTRB=0xF in the same cycle -> BVALID next cycle, BRESP=00; read 0x08 -> RDATA=0xDEADBEEF, RRESP=00.
- W first (0x11223344, WSTRB=0x5), AW=0x04 three cycles later, reg1 previously 0xFFFFFFFF -> reg1=0xFF22FF44, one B response only.
- Write and read at 0x40 with NUM_REGS=16 -> BRESP=10, RRESP=10, RDATA=0, no register changes.
- Hold BREADY=0 for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout; same for RREADY=0 with RVALID/RDATA stable.
- Assert ARESETn low mid-write (AW latched, W not yet) -> all outputs 0; after release, W alone must not produce a BVALID; regs remain 0.
- With AXIL_REGFILE_WR_PULSE_EN, write reg 3 -> wr_pulse=0x0008 for one cycle aligned to BVALID rise; miss write -> wr_pulse stays 0.

Source files
------------

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - response codes, FSM state types and width helpers for the AXI4-Lite register file
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, HAVE_AW, HAVE_W, RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_RESP} rd_state_e;

    function automatic int strb_w(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axil_wr_chan.sv
// rtl/axil_wr_chan.sv - AXI4-Lite write channel: AW/W latching in any order, decode, commit strobe, B response
module axil_wr_chan
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [1:0]              b_resp,
    output logic                    commit,
    output logic [IDX_W-1:0]        commit_idx,
    output logic                    commit_hit,
    output logic [DATA_WIDTH-1:0]   commit_data,
    output logic [DATA_WIDTH/8-1:0] commit_strb
);

    localparam int STRB_W = strb_w(DATA_WIDTH);
    localparam int LSB    = addr_lsb(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] NREG = ADDR_WIDTH'(NUM_REGS);

    wr_state_e               state;
    logic                    active;
    logic [ADDR_WIDTH-1:0]   aw_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_W-1:0]       w_strb_q;
    logic                    aw_hs;
    logic                    w_hs;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH:0]     diff;
    logic [ADDR_WIDTH-1:0]   word;

    // active keeps the READYs low until the first edge after reset release
    assign aw_ready = active && (state == IDLE || state == HAVE_W);
    assign w_ready  = active && (state == IDLE || state == HAVE_AW);
    assign aw_hs    = aw_valid && aw_ready;
    assign w_hs     = w_valid && w_ready;
    assign b_valid  = (state == RESP);

    // Commit when both halves are present, whether just handshaken or already latched
    assign commit      = (aw_hs || state == HAVE_AW) && (w_hs || state == HAVE_W);
    assign addr        = aw_hs ? aw_addr : aw_addr_q;
    assign commit_data = w_hs ? w_data : w_data_q;
    assign commit_strb = w_hs ? w_strb : w_strb_q;

    // Borrow out of the subtraction flags addresses below the base
    assign diff       = {1'b0, addr} - {1'b0, BASE_ADDR};
    assign word       = diff[ADDR_WIDTH-1:0] >> LSB;
    assign commit_hit = !diff[ADDR_WIDTH] && (word < NREG);
    assign commit_idx = word[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            active    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_resp    <= RESP_OKAY;
        end else begin
            active <= 1'b1;
            if (aw_hs) aw_addr_q <= aw_addr;
            if (w_hs) begin
                w_data_q <= w_data;
                w_strb_q <= w_strb;
            end
            if (commit) b_resp <= commit_hit ? RESP_OKAY : RESP_SLVERR;
            case (state)
                IDLE: begin
                    if (commit)     state <= RESP;
                    else if (aw_hs) state <= HAVE_AW;
                    else if (w_hs)  state <= HAVE_W;
                end
                HAVE_AW, HAVE_W: if (commit) state <= RESP;
                RESP: if (b_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axil_regfile_slave.sv
// rtl/axil_regfile_slave.sv - AXI4-Lite slave with NUM_REGS byte-strobed registers and a read FSM
// Optional AXIL_REGFILE_WR_PULSE_EN adds a per-register one-cycle write pulse aligned to BVALID.
module axil_regfile_slave
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           WVALID,
    output logic                           WREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    output logic                           BVALID,
    input  logic                           BREADY,
    output logic [1:0]                     BRESP,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
`ifdef AXIL_REGFILE_WR_PULSE_EN
    ,
    output logic [NUM_REGS-1:0]            wr_pulse
`endif
);

    localparam int STRB_W = strb_w(DATA_WIDTH);
    localparam int LSB    = addr_lsb(DATA_WIDTH);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NREG = ADDR_WIDTH'(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  commit;
    logic [IDX_W-1:0]      commit_idx;
    logic                  commit_hit;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [STRB_W-1:0]     commit_strb;

    axil_wr_chan #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BASE_ADDR  (BASE_ADDR)
    ) u_wr_chan (
        .clk         (ACLK),
        .rst_n       (ARESETn),
        .aw_valid    (AWVALID),
        .aw_ready    (AWREADY),
        .aw_addr     (AWADDR),
        .w_valid     (WVALID),
        .w_ready     (WREADY),
        .w_data      (WDATA),
        .w_strb      (WSTRB),
        .b_valid     (BVALID),
        .b_ready     (BREADY),
        .b_resp      (BRESP),
        .commit      (commit),
        .commit_idx  (commit_idx),
        .commit_hit  (commit_hit),
        .commit_data (commit_data),
        .commit_strb (commit_strb)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit && commit_hit) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (commit_strb[b]) regs[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

`ifdef AXIL_REGFILE_WR_PULSE_EN
    // Registered from the commit edge, so it lines up with BVALID rising
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit && commit_hit) wr_pulse[commit_idx] <= 1'b1;
        end
    end
`endif

    rd_state_e             r_state;
    logic                  r_active;
    logic                  ar_hs;
    logic [ADDR_WIDTH:0]   ar_diff;
    logic [ADDR_WIDTH-1:0] ar_word;
    logic                  ar_hit;
    logic [IDX_W-1:0]      ar_idx;

    assign ARREADY = r_active && (r_state == R_IDLE);
    assign RVALID  = (r_state == R_RESP);
    assign ar_hs   = ARVALID && ARREADY;
    assign ar_diff = {1'b0, ARADDR} - {1'b0, BASE_ADDR};
    assign ar_word = ar_diff[ADDR_WIDTH-1:0] >> LSB;
    assign ar_hit  = !ar_diff[ADDR_WIDTH] && (ar_word < NREG);
    assign ar_idx  = ar_word[IDX_W-1:0];

    // Non-blocking sample of regs gives the pre-write value on a same-edge collision
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state  <= R_IDLE;
            r_active <= 1'b0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
        end else begin
            r_active <= 1'b1;
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state <= R_RESP;
                        RDATA   <= ar_hit ? regs[ar_idx] : '0;
                        RRESP   <= ar_hit ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_RESP: if (RREADY) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb/tb_axil_regfile_slave.sv - directed self-checking bench for axil_regfile_slave (default parameters)
module tb_axil_regfile_slave;

    logic         ACLK = 1'b0;
    logic         ARESETn = 1'b1;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  AWADDR = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         BVALID;
    logic         BREADY = 1'b0;
    logic [1:0]   BRESP;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  ARADDR = '0;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic [511:0] regs_q;
`ifdef AXIL_REGFILE_WR_PULSE_EN
    logic [15:0]  wr_pulse;
`endif

    int checks = 0;
    int fails  = 0;
    logic [31:0] model [16];

    always #5 ACLK = ~ACLK;

    axil_regfile_slave dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .AWADDR  (AWADDR),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .BRESP   (BRESP),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .ARADDR  (ARADDR),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .regs_q  (regs_q)
`ifdef AXIL_REGFILE_WR_PULSE_EN
        ,
        .wr_pulse (wr_pulse)
`endif
    );

    function automatic logic [511:0] packed_model();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = model[i];
        return v;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output bit ok);
        int n;
        ok = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = a; WVALID = 1'b1; WDATA = d; WSTRB = s;
        n = 0;
        while (!(AWREADY && WREADY) && n < 20) begin @(negedge ACLK); n++; end
        if (n >= 20) ok = 1'b0;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        n = 0;
        while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
        if (!BVALID) ok = 1'b0;
        resp = BRESP;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output bit ok);
        int n;
        ok = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b1; ARADDR = a;
        n = 0;
        while (!ARREADY && n < 20) begin @(negedge ACLK); n++; end
        if (n >= 20) ok = 1'b0;
        @(negedge ACLK);
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 20) begin @(negedge ACLK); n++; end
        if (!RVALID) ok = 1'b0;
        d = RDATA; resp = RRESP;
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        #1 ARESETn = 1'b0;
        repeat (2) @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
        checks++;
        if ({BRESP, RRESP, RDATA} !== 36'h0) begin
            fails++; $display("FAIL reset_data: got %h expected 0", {BRESP, RRESP, RDATA});
        end
        checks++;
        if (regs_q !== 512'h0) begin fails++; $display("FAIL reset_regs: regs_q not zero"); end
        ARESETn = 1'b1;
        #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
            fails++; $display("FAIL ready_before_edge: got %b expected 000", {AWREADY, WREADY, ARREADY});
        end
        @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            fails++; $display("FAIL ready_after_edge: got %b expected 111", {AWREADY, WREADY, ARREADY});
        end
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask

    task automatic test_same_cycle();
        logic [31:0] d; logic [1:0] r; bit ok;
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = 32'h08; WVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        model[2] = 32'hDEADBEEF;
        checks++;
        if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b10000) begin
            fails++; $display("FAIL same_cycle_b: got %b expected 10000", {BVALID, BRESP, AWREADY, WREADY});
        end
        checks++;
        if (regs_q !== packed_model()) begin fails++; $display("FAIL same_cycle_regs: got %h expected deadbeef", regs_q[95:64]); end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        checks++;
        if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
            fails++; $display("FAIL same_cycle_release: got %b expected 011", {BVALID, AWREADY, WREADY});
        end
        do_read(32'h08, d, r, ok);
        checks++;
        if (!ok || d !== 32'hDEADBEEF || r !== 2'b00) begin
            fails++; $display("FAIL same_cycle_read: got %h/%b ok=%0d expected deadbeef/00", d, r, ok);
        end
    endtask

    task automatic test_w_first();
        logic [1:0] r; bit ok; int stray;
        do_write(32'h04, 32'hFFFFFFFF, 4'hF, r, ok);
        model[1] = 32'hFFFFFFFF;
        checks++;
        if (!ok || r !== 2'b00) begin fails++; $display("FAIL w_first_prefill: got %b ok=%0d expected 00", r, ok); end
        @(negedge ACLK);
        WVALID = 1'b1; WDATA = 32'h11223344; WSTRB = 4'h5;
        @(negedge ACLK);
        WVALID = 1'b0;
        checks++;
        if ({AWREADY, WREADY, BVALID} !== 3'b100) begin
            fails++; $display("FAIL w_first_have_w: got %b expected 100", {AWREADY, WREADY, BVALID});
        end
        stray = 0;
        repeat (2) begin @(negedge ACLK); if (BVALID) stray++; end
        AWVALID = 1'b1; AWADDR = 32'h04;
        @(negedge ACLK);
        AWVALID = 1'b0;
        model[1] = 32'hFF22FF44;
        checks++;
        if (stray != 0 || {BVALID, BRESP} !== 3'b100) begin
            fails++; $display("FAIL w_first_b: got %b early=%0d expected 100 early=0", {BVALID, BRESP}, stray);
        end
        checks++;
        if (regs_q[63:32] !== 32'hFF22FF44 || regs_q !== packed_model()) begin
            fails++; $display("FAIL w_first_strobe: got %h expected ff22ff44", regs_q[63:32]);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        stray = 0;
        repeat (4) begin if (BVALID) stray++; @(negedge ACLK); end
        checks++;
        if (stray != 0) begin fails++; $display("FAIL w_first_single_b: got %0d extra BVALID cycles expected 0", stray); end
    endtask

    task automatic test_miss_and_bounds();
        logic [31:0] d; logic [1:0] r; bit ok;
        do_write(32'h40, 32'h12345678, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 2'b10) begin fails++; $display("FAIL miss_bresp: got %b ok=%0d expected 10", r, ok); end
        checks++;
        if (regs_q !== packed_model()) begin fails++; $display("FAIL miss_no_write: register bank changed"); end
        do_read(32'h40, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0 || r !== 2'b10) begin
            fails++; $display("FAIL miss_read: got %h/%b expected 00000000/10", d, r);
        end
        do_write(32'h3C, 32'hCAFEF00D, 4'hF, r, ok);
        model[15] = 32'hCAFEF00D;
        do_read(32'h3C, d, r, ok);
        checks++;
        if (!ok || d !== 32'hCAFEF00D || r !== 2'b00 || regs_q !== packed_model()) begin
            fails++; $display("FAIL last_reg: got %h/%b expected cafef00d/00", d, r);
        end
        do_read(32'h0B, d, r, ok);
        checks++;
        if (!ok || d !== 32'hDEADBEEF || r !== 2'b00) begin
            fails++; $display("FAIL subword_addr: got %h/%b expected deadbeef/00", d, r);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = 32'h0C; WVALID = 1'b1; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF;
        @(negedge ACLK);
        AWADDR = 32'h10; WDATA = 32'h0BADBAD0;
        model[3] = 32'hA5A5A5A5;
        bad = 0;
        repeat (5) begin
            if (!(BVALID && BRESP == 2'b00 && !AWREADY && !WREADY)) bad++;
            @(negedge ACLK);
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        checks++;
        if (bad != 0) begin fails++; $display("FAIL b_backpressure: got %0d bad cycles expected 0", bad); end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        checks++;
        if (BVALID !== 1'b0 || regs_q !== packed_model()) begin
            fails++; $display("FAIL b_backpressure_end: BVALID=%b or bank wrong, expected 0 and one write", BVALID);
        end
        ARVALID = 1'b1; ARADDR = 32'h0C;
        @(negedge ACLK);
        ARADDR = 32'h08;
        bad = 0;
        repeat (5) begin
            if (!(RVALID && RDATA == 32'hA5A5A5A5 && RRESP == 2'b00 && !ARREADY)) bad++;
            @(negedge ACLK);
        end
        ARVALID = 1'b0;
        checks++;
        if (bad != 0) begin fails++; $display("FAIL r_backpressure: got %0d bad cycles expected 0", bad); end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        checks++;
        if ({RVALID, ARREADY} !== 2'b01) begin fails++; $display("FAIL r_release: got %b expected 01", {RVALID, ARREADY}); end
    endtask

    task automatic test_rw_collision();
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = 32'h0C; WVALID = 1'b1; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF;
        ARVALID = 1'b1; ARADDR = 32'h0C;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        model[3] = 32'h5A5A5A5A;
        checks++;
        if (!RVALID || RDATA !== 32'hA5A5A5A5) begin
            fails++; $display("FAIL collision_read: got %h expected a5a5a5a5 (pre-write)", RDATA);
        end
        checks++;
        if (!BVALID || regs_q !== packed_model()) begin
            fails++; $display("FAIL collision_write: got %h expected 5a5a5a5a", regs_q[127:96]);
        end
        BREADY = 1'b1; RREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0; RREADY = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int stray;
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = 32'h10;
        @(negedge ACLK);
        AWVALID = 1'b0;
        checks++;
        if ({AWREADY, WREADY} !== 2'b01) begin fails++; $display("FAIL mid_have_aw: got %b expected 01", {AWREADY, WREADY}); end
        #2 ARESETn = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA} !== 41'h0 || regs_q !== 512'h0) begin
            fails++; $display("FAIL mid_reset_outputs: got %h expected all zero", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA});
        end
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b1; WDATA = 32'h77777777; WSTRB = 4'hF;
        @(negedge ACLK);
        WVALID = 1'b0;
        stray = 0;
        repeat (4) begin if (BVALID) stray++; @(negedge ACLK); end
        checks++;
        if (stray != 0 || regs_q !== 512'h0) begin
            fails++; $display("FAIL mid_stale_aw: got %0d BVALID cycles expected 0 and zero regs", stray);
        end
        ARESETn = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
    endtask

`ifdef AXIL_REGFILE_WR_PULSE_EN
    task automatic test_wr_pulse();
        logic [15:0] seen;
        @(negedge ACLK);
        checks++;
        if (wr_pulse !== 16'h0) begin fails++; $display("FAIL pulse_idle: got %h expected 0000", wr_pulse); end
        AWVALID = 1'b1; AWADDR = 32'h0C; WVALID = 1'b1; WDATA = 32'h1; WSTRB = 4'hF;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        checks++;
        if (!BVALID || wr_pulse !== 16'h0008) begin fails++; $display("FAIL pulse_reg3: got %h expected 0008", wr_pulse); end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        checks++;
        if (wr_pulse !== 16'h0) begin fails++; $display("FAIL pulse_width: got %h expected 0000", wr_pulse); end
        AWVALID = 1'b1; AWADDR = 32'h40; WVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        seen = wr_pulse;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        checks++;
        if (seen !== 16'h0) begin fails++; $display("FAIL pulse_miss: got %h expected 0000", seen); end
        AWVALID = 1'b1; AWADDR = 32'h14; WVALID = 1'b1; WSTRB = 4'h0;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        checks++;
        if (wr_pulse !== 16'h0020) begin fails++; $display("FAIL pulse_zero_strb: got %h expected 0020", wr_pulse); end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_same_cycle();
        test_w_first();
        test_miss_and_bounds();
        test_backpressure();
        test_rw_collision();
        test_reset_mid_write();
`ifdef AXIL_REGFILE_WR_PULSE_EN
        test_wr_pulse();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
